bcd_countdown_timer: RTL and testbench
======================================

// Module: bcd_countdown_timer
// PURPOSE
//  Time-keeping register that consumes the mm:ss BCD value produced by the add/sub minute-adjust path.
//  - Holds the time, counts it down once per second while running, and flags expiry at 00:00.
//  - Sits between the adjust logic (writer of the load value) and the display/alarm logic (readers of time_bcd/expired).
//  - Digit map: [3:0] sec units, [7:4] sec tens, [11:8] min units, [15:12] min tens.
// PARAMETERS
//  TICKS_PER_SEC  50_000_000  clk cycles per one-second decrement; legal range >= 2
// PORTS
//  clk           in   1   system clock; all logic on rising edge
//  rst_n         in   1   synchronous, active-low reset
//  load_valid    in   1   1-cycle pulse; load_time is valid (driven from add|sub of the adjust path)
//  load_time     in   16  BCD mm:ss value to load
//  start         in   1   1-cycle pulse; begin/resume countdown
//  stop          in   1   1-cycle pulse; pause countdown
//  time_bcd      out  16  current BCD mm:ss value
//  running       out  1   1 while in RUN
//  expired       out  1   level; 1 while in DONE
//  expire_pulse  out  1   1-cycle pulse on the RUN->DONE transition
//  load_err      out  1   1-cycle pulse when a load was rejected as non-BCD
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge):
//   - state=IDLE, time_bcd=16'h0000, prescaler=0.
//   - running=expired=expire_pulse=load_err=0.
//  States:
//   - IDLE: holds time_bcd. start with time!=0 -> RUN. start with time==0 is ignored.
//   - RUN: prescaler counts 0..TICKS_PER_SEC-1; the wrap cycle is a tick.
//     - tick: time_bcd decremented by 1 s with BCD borrow (ss 00 -> 59, min borrows; min tens 0..9).
//     - tick with time==00:01: time becomes 0000, state -> DONE, expire_pulse=1 in the same cycle the register shows 0000.
//     - stop -> IDLE; time held, prescaler cleared.
//   - DONE: time_bcd=0000, expired=1. start/stop ignored. load_valid (valid BCD) -> IDLE with new time.
//  Load:
//   - Legal BCD only: digits<=9, sec tens<=5. Illegal value: state/time unchanged, load_err=1 next cycle.
//   - Legal load: time_bcd=load_time next cycle, prescaler cleared, state unchanged.
//     - Exception 1: in DONE, state -> IDLE.
//     - Exception 2: in RUN, a load of 0000 -> IDLE (no expiry).
//  Priority in one cycle: reset > load_valid > stop > start > tick.
//   - Load and tick together: the load wins and the tick is discarded.
//   - start+stop together in IDLE/RUN: stop wins (-> IDLE).
//  Latency: every input takes effect at the next clk edge. Outputs are registered, with no combinational input->output paths.
//  Reset mid-RUN: immediate IDLE/0000; no expire_pulse.
// STRUCTURE
//  Package timer_pkg:
//   - typedef enum logic [1:0] {IDLE, RUN, DONE} timer_state_t.
//   - Constants BCD_MAX_UNITS=4'd9, BCD_MAX_SEC_TENS=4'd5.
//   - function is_valid_bcd_time(logic [15:0]).
//  Sub-module bcd_digit_down:
//   - Ports: digit, max, borrow_in -> next_digit, borrow_out.
//   - Instantiated 4x as a ripple chain.
//  Top: prescaler counter with $clog2(TICKS_PER_SEC) bits, FSM, load validation.
// TESTING (TICKS_PER_SEC=4)
//  1. Reset, load 16'h0012, start -> ticks every 4 clks: 0011, 0010, 0009 (BCD borrow, never 000F).
//  2. Load 16'h0100, start -> after 1 tick time=0059. Load 16'h1000, start -> after 1 tick time=0959.
//  3. Load 16'h0002, start -> 0001, then 0000 with expire_pulse for exactly 1 clk. expired stays 1. start is ignored.
//     Then load 16'h0030 -> IDLE, expired=0.
//  4. Load 16'h0075 (sec tens 7) and 16'h00A0 -> load_err pulse each, time_bcd unchanged.
//  5. RUN at 0005, assert load_valid=16'h0020 on a tick cycle -> time=0020 and the prescaler restarts.
//     start+stop in one cycle -> IDLE.
//  6. RUN at 0003, rst_n=0 for 1 clk mid-count -> 0000, IDLE, no expire_pulse. start at 0000 -> stays IDLE.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding, BCD digit limits and load validation for the countdown timer.
package timer_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} timer_state_t;

    localparam logic [3:0] BCD_MAX_UNITS    = 4'd9;
    localparam logic [3:0] BCD_MAX_SEC_TENS = 4'd5;

    function automatic logic is_valid_bcd_time(input logic [15:0] t);
        return t[15:12] <= BCD_MAX_UNITS && t[11:8] <= BCD_MAX_UNITS &&
               t[7:4] <= BCD_MAX_SEC_TENS && t[3:0] <= BCD_MAX_UNITS;
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// bcd_digit_down: one BCD digit of a ripple-borrow decrementer; wraps 0 to max on borrow.
module bcd_digit_down (
    input  logic [3:0] digit,
    input  logic [3:0] max,
    input  logic       borrow_in,
    output logic [3:0] next_digit,
    output logic       borrow_out
);

    assign next_digit = borrow_in ? ((digit == 4'd0) ? max : digit - 4'd1) : digit;
    assign borrow_out = borrow_in && digit == 4'd0;

endmodule

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: mm:ss BCD countdown register with load validation, run/stop control and expiry flags.
module bcd_countdown_timer
    import timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_valid,
    input  logic [15:0] load_time,
    input  logic        start,
    input  logic        stop,
    output logic [15:0] time_bcd,
    output logic        running,
    output logic        expired,
    output logic        expire_pulse,
    output logic        load_err
);

    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] LAST = PW'(TICKS_PER_SEC - 1);

    timer_state_t  state_q, state_d;
    logic [15:0]   time_q, time_d, dec;
    logic [PW-1:0] presc_q, presc_d;
    logic          pulse_q, pulse_d, err_q, err_d;
    logic [4:0]    borrow;
    logic          tick;

    assign tick      = state_q == RUN && presc_q == LAST;
    assign borrow[0] = tick;

    for (genvar i = 0; i < 4; i++) begin : g_dig
        bcd_digit_down u_digit (
            .digit      (time_q[4*i +: 4]),
            .max        (i == 1 ? BCD_MAX_SEC_TENS : BCD_MAX_UNITS),
            .borrow_in  (borrow[i]),
            .next_digit (dec[4*i +: 4]),
            .borrow_out (borrow[i+1])
        );
    end

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        presc_d = (state_q == RUN) ? (tick ? '0 : presc_q + 1'b1) : presc_q;
        pulse_d = 1'b0;
        err_d   = 1'b0;
        if (load_valid) begin
            if (is_valid_bcd_time(load_time)) begin
                time_d  = load_time;
                presc_d = '0;
                if (state_q == DONE || (state_q == RUN && load_time == 16'h0000))
                    state_d = IDLE;
            end else begin
                err_d = 1'b1;
            end
        end else if (stop && state_q != DONE) begin
            state_d = IDLE;
            presc_d = '0;
        end else if (start && state_q == IDLE && time_q != 16'h0000) begin
            state_d = RUN;
            presc_d = '0;
        end else if (tick && !borrow[4]) begin
            // a borrow out of the top digit would mean wrapping past 00:00
            time_d = dec;
            if (dec == 16'h0000) begin
                state_d = DONE;
                pulse_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            time_q  <= 16'h0000;
            presc_q <= '0;
            pulse_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            presc_q <= presc_d;
            pulse_q <= pulse_d;
            err_q   <= err_d;
        end
    end

    assign time_bcd     = time_q;
    assign running      = state_q == RUN;
    assign expired      = state_q == DONE;
    assign expire_pulse = pulse_q;
    assign load_err     = err_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb_bcd_countdown_timer: vector table, corner sequences and randomized run against a seconds-based model.
module tb_bcd_countdown_timer;

    localparam int TPS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_time = 16'h0000;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] time_bcd;
    logic        running, expired, expire_pulse, load_err;

    int total = 0;
    int bad = 0;

    bcd_countdown_timer #(.TICKS_PER_SEC(TPS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_valid   (load_valid),
        .load_time    (load_time),
        .start        (start),
        .stop         (stop),
        .time_bcd     (time_bcd),
        .running      (running),
        .expired      (expired),
        .expire_pulse (expire_pulse),
        .load_err     (load_err)
    );

    always #5 clk = ~clk;

    // model keeps time as plain seconds; 0 idle, 1 run, 2 done
    int m_state = 0;
    int m_sec = 0;
    int m_pre = 0;
    bit m_pulse = 0;
    bit m_err = 0;

    function automatic bit legal(input logic [15:0] v);
        return v[15:12] < 10 && v[11:8] < 10 && v[7:4] < 6 && v[3:0] < 10;
    endfunction

    function automatic int bcd2sec(input logic [15:0] v);
        return (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [15:0] sec2bcd(input int s);
        int m, q;
        m = s / 60;
        q = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(q / 10), 4'(q % 10)};
    endfunction

    task automatic model_step(input logic r, lv, input logic [15:0] lt, input logic st, sp);
        bit tk;
        int pn;
        if (!r) begin
            m_state = 0; m_sec = 0; m_pre = 0; m_pulse = 0; m_err = 0;
            return;
        end
        m_pulse = 0;
        m_err = 0;
        tk = m_state == 1 && m_pre == TPS - 1;
        pn = (m_state == 1) ? (m_pre + 1) % TPS : m_pre;
        if (lv) begin
            if (legal(lt)) begin
                m_sec = bcd2sec(lt);
                m_pre = 0;
                if (m_state == 2 || (m_state == 1 && m_sec == 0)) m_state = 0;
            end else begin
                m_err = 1;
                m_pre = pn;
            end
        end else if (sp && m_state != 2) begin
            m_state = 0;
            m_pre = 0;
        end else if (st && m_state == 0 && m_sec != 0) begin
            m_state = 1;
            m_pre = 0;
        end else begin
            m_pre = pn;
            if (tk) begin
                m_sec--;
                if (m_sec == 0) begin
                    m_state = 2;
                    m_pulse = 1;
                end
            end
        end
    endtask

    task automatic cyc(input logic r, lv, input logic [15:0] lt, input logic st, sp);
        rst_n = r; load_valid = lv; load_time = lt; start = st; stop = sp;
        model_step(r, lv, lt, st, sp);
        @(posedge clk);
        #1;
        rst_n = 1'b1; load_valid = 1'b0; start = 1'b0; stop = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1, 0, 16'h0, 0, 0);
    endtask

    task automatic chk(input string nm, input logic [15:0] t, input logic r, e, p, er);
        total++;
        if ({time_bcd, running, expired, expire_pulse, load_err} !== {t, r, e, p, er}) begin
            bad++;
            $display("FAIL %s: got time=%h run=%b exp=%b pulse=%b err=%b, want time=%h run=%b exp=%b pulse=%b err=%b",
                     nm, time_bcd, running, expired, expire_pulse, load_err, t, r, e, p, er);
        end
    endtask

    typedef struct {
        logic r, lv;
        logic [15:0] lt;
        logic st, sp;
        int idle;
        logic [15:0] t;
        logic run, exp, pls, err;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        tbl.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 16'h0012, 1'b0, 1'b0, 0, 16'h0012, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 16'h0012, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 3, 16'h0011, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 3, 16'h0010, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 3, 16'h0009, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 0, 16'h0009, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 16'h0100, 1'b0, 1'b0, 0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 16'h0100, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 3, 16'h0059, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 0, 16'h0059, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 16'h1000, 1'b0, 1'b0, 0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 16'h1000, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 3, 16'h0959, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 0, 16'h0959, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 16'h0075, 1'b0, 1'b0, 0, 16'h0959, 1'b0, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 16'h00A0, 1'b0, 1'b0, 0, 16'h0959, 1'b0, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 16'h0959, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 0, 16'h0959, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 16'h0959, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 0, 16'h0959, 1'b0, 1'b0, 1'b0, 1'b0});

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].r, tbl[i].lv, tbl[i].lt, tbl[i].st, tbl[i].sp);
            idle(tbl[i].idle);
            chk($sformatf("vec%0d", i), tbl[i].t, tbl[i].run, tbl[i].exp, tbl[i].pls, tbl[i].err);
        end

        // expiry: pulse lasts one clock, DONE ignores start/stop, load leaves DONE
        cyc(1, 1, 16'h0002, 0, 0);
        cyc(1, 0, 16'h0, 1, 0);
        idle(4);
        chk("exp_0001", 16'h0001, 1, 0, 0, 0);
        idle(3);
        chk("exp_pre", 16'h0001, 1, 0, 0, 0);
        idle(1);
        chk("exp_hit", 16'h0000, 0, 1, 1, 0);
        idle(1);
        chk("exp_hold", 16'h0000, 0, 1, 0, 0);
        cyc(1, 0, 16'h0, 1, 0);
        chk("exp_start", 16'h0000, 0, 1, 0, 0);
        cyc(1, 0, 16'h0, 0, 1);
        chk("exp_stop", 16'h0000, 0, 1, 0, 0);
        cyc(1, 1, 16'h0030, 0, 0);
        chk("exp_load", 16'h0030, 0, 0, 0, 0);

        // load on a tick cycle wins and restarts the prescaler
        cyc(1, 1, 16'h0005, 0, 0);
        cyc(1, 0, 16'h0, 1, 0);
        idle(3);
        cyc(1, 1, 16'h0020, 0, 0);
        chk("ldtick", 16'h0020, 1, 0, 0, 0);
        idle(3);
        chk("ldtick_hold", 16'h0020, 1, 0, 0, 0);
        idle(1);
        chk("ldtick_next", 16'h0019, 1, 0, 0, 0);
        cyc(1, 1, 16'h0000, 0, 0);
        chk("run_load0", 16'h0000, 0, 0, 0, 0);
        idle(5);
        chk("run_load0_quiet", 16'h0000, 0, 0, 0, 0);

        // reset mid-count
        cyc(1, 1, 16'h0003, 0, 0);
        cyc(1, 0, 16'h0, 1, 0);
        idle(6);
        chk("rst_pre", 16'h0002, 1, 0, 0, 0);
        cyc(0, 0, 16'h0, 0, 0);
        chk("rst_mid", 16'h0000, 0, 0, 0, 0);
        idle(6);
        chk("rst_quiet", 16'h0000, 0, 0, 0, 0);
        cyc(1, 0, 16'h0, 1, 0);
        chk("start_zero", 16'h0000, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            logic r, lv, st, sp;
            logic [15:0] lt;
            r  = $urandom_range(0, 199) != 0;
            lv = $urandom_range(0, 99) < 5;
            st = $urandom_range(0, 99) < 10;
            sp = $urandom_range(0, 99) < 3;
            lt = ($urandom_range(0, 3) == 0) ? 16'($urandom()) : sec2bcd($urandom_range(0, 12));
            cyc(r, lv, lt, st, sp);
            chk($sformatf("rand%0d", i), sec2bcd(m_sec), m_state == 1, m_state == 2, m_pulse, m_err);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
